// File: rtl/lsu_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// lsu_bus_ctrl_pkg : shared access-width and controller-state definitions
// Revision : 1.0
// ============================================================================
package lsu_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/lsu_bus_ctrl_load_align.sv
`default_nettype none
// ============================================================================
// lsu_bus_ctrl_load_align : shifts a bus word down to the accessed byte lane
// and sign/zero-extends it to 32 bits.          Revision : 1.0
// ============================================================================
module lsu_bus_ctrl_load_align
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  byte_idx_i,
    input  mem_width_e  width_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        ext_bit;

    always_comb begin
        shifted = rdata_i >> {byte_idx_i, 3'b000};
        ext_bit = 1'b0;
        data_o  = shifted;
        case (width_i)
            BYTE: begin
                ext_bit = shifted[7] & ~unsigned_i;
                data_o  = {{24{ext_bit}}, shifted[7:0]};
            end
            HALF: begin
                ext_bit = shifted[15] & ~unsigned_i;
                data_o  = {{16{ext_bit}}, shifted[15:0]};
            end
            default: data_o = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_bus_ctrl : single-outstanding req/gnt/rvalid data-bus controller.
// Optional bus timeout enabled with LSU_TIMEOUT_EN.   Revision : 1.0
// ============================================================================
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  mem_width_e  req_width_i,
    input  logic        req_unsigned_i,
    input  logic [1:0]  req_byte_idx_i,
    input  logic [31:0] req_word_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_strobe_i,
    input  logic        req_illegal_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    mem_width_e  width_q, width_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timeout_hit;
    logic [31:0] aligned;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count is the number of bus cycles already spent in REQ+WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q == REQ || state_q == WAIT) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        width_d    = width_q;
        unsigned_d = unsigned_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d    = req_write_i;
                    width_d    = req_width_i;
                    unsigned_d = req_unsigned_i;
                    byte_idx_d = req_byte_idx_i;
                    addr_d     = req_word_addr_i;
                    wdata_d    = req_wdata_i;
                    be_d       = req_write_i ? req_strobe_i : BE_ALL;
                    rdata_d    = '0;
                    err_d      = req_illegal_i;
                    state_d    = req_illegal_i ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    err_d   = mem_err_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            width_q    <= BYTE;
            unsigned_q <= 1'b0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            width_q    <= width_d;
            unsigned_q <= unsigned_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    lsu_bus_ctrl_load_align u_load_align (
        .rdata_i    (rdata_q),
        .byte_idx_i (byte_idx_q),
        .width_i    (width_q),
        .unsigned_i (unsigned_q),
        .data_o     (aligned)
    );

    // Bus and response outputs depend only on state and captured registers.
    assign req_ready_o = (state_q == IDLE);
    assign mem_req_o   = (state_q == REQ);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = write_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = (state_q == RESP) && err_q;
    assign rsp_data_o  = ((state_q == RESP) && !err_q && !write_q) ? aligned : 32'h0;

endmodule
`default_nettype wire
